// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage feeding decode.
// Generates sequential word addresses and keeps one request outstanding
// towards the MMU. Returned words are buffered together with their
// addresses in a small prefetch FIFO. A branch redirect flushes the FIFO
// and squashes any response still in flight.
module core_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        insn_ready,
    input  logic [31:0] insn_data_rd,
    output logic        insn_start,
    output logic [29:0] insn_addr,
    input  logic        branch,
    input  logic [29:0] branch_target,
    input  logic        stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_insn,
    output logic [29:0] fetch_pc
);

    // Pointer width indexes DEPTH entries; count width holds 0..DEPTH.
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // IDLE: nothing in flight. WAIT: one live request. DRAIN: one squashed
    // request whose response must be swallowed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q,   state_d;
    logic [29:0]     next_pc_q, next_pc_d;
    logic            start_q,   start_d;
    logic [29:0]     addr_q,    addr_d;
    logic [CW-1:0]   count_q,   count_d;
    logic [PW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,  wr_ptr_d;

    // Prefetch storage: instruction word and its word address per entry.
    logic [31:0]     data_mem [DEPTH];
    logic [29:0]     pc_mem   [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic            push;
    logic            pop;
    logic            slot_free;
    logic            room;
    logic            issue;
    logic [29:0]     issue_addr;
    logic [CW-1:0]   count_after;

    assign fetch_valid = (count_q != '0);
    // Head data is gated by valid so an empty FIFO always presents zeros.
    assign fetch_insn  = fetch_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign fetch_pc    = fetch_valid ? pc_mem[rd_ptr_q]   : 30'h0;
    assign insn_start  = start_q;
    assign insn_addr   = addr_q;

    // Handshake and occupancy decode for this cycle.
    always_comb begin
        push        = 1'b0;
        pop         = 1'b0;
        slot_free   = 1'b0;
        count_after = count_q;
        // A response arriving together with a branch is dropped.
        push = (state_q == ST_WAIT) && insn_ready && !branch;
        pop  = fetch_valid && !stall && !branch;
        // The request slot is free either because nothing is in flight or
        // because the outstanding response is arriving this cycle.
        slot_free = (state_q == ST_IDLE) ||
                    (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && insn_ready);
        if (branch) begin
            count_after = '0;
        end else if (push && !pop) begin
            count_after = count_q + 1'b1;
        end else if (pop && !push) begin
            count_after = count_q - 1'b1;
        end
    end

    // A new request only goes out if its response is guaranteed a slot.
    assign room       = (count_after < DEPTH_C);
    assign issue      = slot_free && room;
    assign issue_addr = branch ? branch_target : next_pc_q;

    // Next-state and request generation; a branch takes priority.
    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        start_d   = 1'b0;
        addr_d    = addr_q;
        count_d   = count_after;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;

        if (branch) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            next_pc_d = branch_target;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        if (issue) begin
            // Issuing in the same cycle a response lands keeps the port
            // busy back-to-back; a branch redirects this very request.
            start_d   = 1'b1;
            addr_d    = issue_addr;
            next_pc_d = issue_addr + 30'd1;
            state_d   = ST_WAIT;
        end else if (slot_free) begin
            state_d = ST_IDLE;
        end else if (branch && (state_q == ST_WAIT)) begin
            state_d = ST_DRAIN;
        end
    end

    // Control state with asynchronous reset; any request in flight is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            next_pc_q <= RESET_PC;
            start_q   <= 1'b0;
            addr_q    <= 30'h0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            start_q   <= start_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // One-hot write enable per FIFO entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == PW'(gi));
        end
    endgenerate

    // FIFO storage needs no reset: contents are only visible when counted valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                data_mem[i] <= insn_data_rd;
                pc_mem[i]   <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: self-checking bench for core_fetch.
// A behavioural MMU answers each request after a programmable latency; every
// accepted response is queued as an expected entry and compared in order
// when decode pops it from the FIFO.
module tb_core_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h100;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic        insn_ready    = 1'b0;
    logic [31:0] insn_data_rd  = 32'h0;
    logic        insn_start;
    logic [29:0] insn_addr;
    logic        branch        = 1'b0;
    logic [29:0] branch_target = 30'h0;
    logic        stall         = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_insn;
    logic [29:0] fetch_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard: {address, word} of every response that must reach decode.
    logic [61:0] exp_q [$];

    // MMU model state.
    bit          mmu_busy  = 1'b0;
    bit          mmu_hold  = 1'b0;
    bit          squash    = 1'b0;
    int          mmu_cnt   = 0;
    int          mmu_lat   = 1;
    logic [29:0] mmu_addr  = 30'h0;
    logic [29:0] exp_pc    = RESET_PC;
    int          start_cnt = 0;
    int          pop_cnt   = 0;

    core_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .insn_ready    (insn_ready),
        .insn_data_rd  (insn_data_rd),
        .insn_start    (insn_start),
        .insn_addr     (insn_addr),
        .branch        (branch),
        .branch_target (branch_target),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_insn    (fetch_insn),
        .fetch_pc      (fetch_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {2'b00, a} ^ 32'hA5A5A5A5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // MMU, expected-address model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [61:0] e;
        if (!rst_n) begin
            exp_q.delete();
            mmu_busy   = 1'b0;
            squash     = 1'b0;
            insn_ready = 1'b0;
            exp_pc     = RESET_PC;
            start_cnt  = 0;
            pop_cnt    = 0;
        end else begin
            check_eq("valid", fetch_valid, exp_q.size() != 0);
            if (insn_start) begin
                check_eq("one_outstanding", mmu_busy, 0);
                check_eq("start_addr", insn_addr, exp_pc);
                start_cnt++;
            end else if (mmu_busy) begin
                check_eq("addr_hold", insn_addr, mmu_addr);
            end
            if (fetch_valid && !stall && !branch && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("pop_pc", fetch_pc, e[61:32]);
                check_eq("pop_insn", fetch_insn, e[31:0]);
                $display("[TB] pop pc=0x%08h insn=0x%08h", fetch_pc, fetch_insn);
                pop_cnt++;
            end
            insn_ready = 1'b0;
            if (mmu_busy && !mmu_hold) begin
                if (mmu_cnt <= 1) begin
                    insn_ready   = 1'b1;
                    insn_data_rd = word_of(mmu_addr);
                    mmu_busy     = 1'b0;
                    if (!branch && !squash) begin
                        exp_q.push_back({mmu_addr, word_of(mmu_addr)});
                    end
                    squash = 1'b0;
                end else begin
                    mmu_cnt--;
                end
            end
            if (insn_start) begin
                mmu_busy = 1'b1;
                mmu_cnt  = mmu_lat;
                mmu_addr = insn_addr;
                exp_pc   = exp_pc + 30'd1;
            end
            if (branch) begin
                exp_q.delete();
                exp_pc = branch_target;
                if (mmu_busy) begin
                    squash = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks outputs clear at once, then
    // releases and checks the first request goes to RESET_PC.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_start", insn_start, 0);
        check_eq("rst_addr", insn_addr, 0);
        check_eq("rst_valid", fetch_valid, 0);
        check_eq("rst_insn", fetch_insn, 0);
        check_eq("rst_pc", fetch_pc, 0);
        mmu_hold = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_eq("first_start", insn_start, 1);
        check_eq("first_addr", insn_addr, RESET_PC);
    endtask

    task automatic wait_start(input int max_cyc, output logic [29:0] addr, output bit got);
        got  = 1'b0;
        addr = 30'h0;
        for (int i = 0; i < max_cyc; i++) begin
            if (insn_start) begin
                got  = 1'b1;
                addr = insn_addr;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [29:0] a;
        bit          got;
        bit          found;

        // Continuous streaming with varying MMU latency and decode stalls.
        do_reset();
        repeat (40) tick();
        check_eq("stream_pops", pop_cnt >= 15, 1);
        mmu_lat = 3;
        for (int i = 0; i < 60; i++) begin
            stall = 1'($urandom_range(0, 1));
            tick();
        end
        mmu_lat = 1;
        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        stall = 1'b0;

        // Stalled decode: exactly DEPTH requests, the next only after a pop.
        stall = 1'b1;
        do_reset();
        repeat (30) tick();
        check_eq("full_starts", start_cnt, DEPTH);
        check_eq("full_no_start", insn_start, 0);
        check_eq("full_valid", fetch_valid, 1);
        check_eq("full_head_pc", fetch_pc, RESET_PC);
        check_eq("full_head_insn", fetch_insn, word_of(RESET_PC));
        stall = 1'b0;
        tick();
        check_eq("fifth_start", insn_start, 1);
        check_eq("fifth_addr", insn_addr, RESET_PC + 30'd4);

        // Branch while waiting on RESET_PC+5: the response is squashed.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mmu_busy && mmu_addr == RESET_PC + 30'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("wait5_found", found, 1);
        mmu_hold      = 1'b1;
        branch        = 1'b1;
        branch_target = 30'h2000;
        tick();
        branch = 1'b0;
        check_eq("br_valid_drop", fetch_valid, 0);
        tick();
        mmu_hold = 1'b0;
        wait_start(10, a, got);
        check_eq("br_start_seen", got, 1);
        check_eq("br_start_addr", a, 30'h2000);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fetch_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("br_pop_seen", found, 1);
        check_eq("br_pop_pc", fetch_pc, 30'h2000);
        check_eq("br_pop_insn", fetch_insn, word_of(30'h2000));

        // Branch in the same cycle as the response.
        mmu_hold = 1'b1;
        for (int i = 0; i < 20 && !mmu_busy; i++) tick();
        check_eq("same_busy", mmu_busy, 1);
        mmu_hold      = 1'b0;
        branch        = 1'b1;
        branch_target = 30'h3000;
        tick();
        branch = 1'b0;
        check_eq("same_start", insn_start, 1);
        check_eq("same_addr", insn_addr, 30'h3000);
        check_eq("same_valid", fetch_valid, 0);
        repeat (10) tick();

        // Redirect to the top of the address space and wrap to zero.
        branch        = 1'b1;
        branch_target = 30'h3FFFFFFF;
        tick();
        branch = 1'b0;
        wait_start(20, a, got);
        check_eq("wrap_top", {got, a}, {1'b1, 30'h3FFFFFFF});
        tick();
        wait_start(20, a, got);
        check_eq("wrap_zero", {got, a}, {1'b1, 30'h0});
        for (int i = 0; i < 20; i++) begin
            stall = 1'($urandom_range(0, 1));
            tick();
        end
        stall = 1'b0;

        // Reset while a request is outstanding and three entries are buffered.
        stall   = 1'b1;
        mmu_lat = 4;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 3 && mmu_busy) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("pre_rst_found", found, 1);
        mmu_hold = 1'b1;
        check_eq("pre_rst_valid", fetch_valid, 1);
        mmu_lat = 1;
        stall   = 1'b0;
        do_reset();
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
